fir_tap_sequencer: RTL and testbench
====================================

Name: fir_tap_sequencer

Overview:
- Producer side of the FIR multiply stage: accepts one 3-bit signed input sample per strobe and shifts it into a 10-tap delay line.
- Reads the 10 coefficients from the coefficient SRAM and issues exactly 10 contiguous multiply-enable pulses, with coefficient k presented on pulse k. This keeps the downstream multiplier's internal tap counter aligned.
- Sits between the sample input interface, the coefficient SRAM read port and the multiplier/accumulator.

Parameters:
- DATA_W, 3, sample width, signed.
- COEFF_W, 16, coefficient width, signed.
- ADDR_W, 4, coefficient SRAM address width.
- COEFF_BASE, 0, SRAM address of coefficient 0; coefficient k is at COEFF_BASE+k.

Ports:
- iClk12M  in  1  system clock, rising edge.
- iRsn  in  1  reset; asynchronous, active-high (1 = reset asserted).
- iEnSample  in  1  new-sample strobe, single cycle.
- iFirIn  in  DATA_W  input sample, signed.
- oReady  out  1  high = idle and able to accept a sample.
- oCsnRam  out  1  SRAM chip select, active-low, read only.
- oAddrRam  out  ADDR_W  SRAM read address.
- iRdDtRam  in  COEFF_W  SRAM read data; valid 1 cycle after the address with oCsnRam=0.
- oEnMul  out  1  multiply enable pulse.
- oCoeff  out  COEFF_W  coefficient paired with oEnMul.
- oDelay_0..oDelay_9  out  DATA_W each  delay-line taps; tap 0 holds the newest sample.
- oDone  out  1  one-cycle pulse: all 10 products have been issued.
- oOvf  out  1  sticky flag: a sample arrived while busy.

Behaviour:
- Reset (async, any state): state=IDLE, all taps=0, oEnMul=0, oCoeff=0, oCsnRam=1, oAddrRam=0, oDone=0, oOvf=0, read-pending flag=0, tap counter=0. A reset mid-sequence aborts it; no further oEnMul pulses occur.
- States: IDLE, RUN, DRAIN, DONE. oReady=1 only in IDLE.
- Cycle 0, accept:
  - Condition: IDLE and iEnSample=1.
  - Shift: tap k <= tap k-1 for k=9..1, and tap 0 <= iFirIn. The old tap 9 is discarded.
  - Next state: RUN, counter=0.
- RUN, cycles 1..10:
  - oCsnRam=0 and oAddrRam=COEFF_BASE+counter; counter increments each cycle.
  - After counter=9 is issued, go to DRAIN; counter returns to 0.
  - oCsnRam, oAddrRam are registered; oAddrRam holds its last value when oCsnRam=1.
- Read-pending flag: registered copy of "read issued this cycle".
- Output register stage: oEnMul <= read-pending; oCoeff <= iRdDtRam when read-pending, otherwise oCoeff holds.
  - oEnMul is high for exactly cycles 3..12, i.e. 10 contiguous pulses.
  - Cycle 3+k carries coefficient k.
- DRAIN covers cycles 11..12. DONE is cycle 13 with oDone=1; state returns to IDLE at cycle 14.
- Per-sample latency: 14 cycles from accept to next oReady; oDone comes 13 cycles after accept.
- Taps are stable from cycle 1 through the next accept. They never change while oEnMul is high.
- iEnSample when not IDLE: the sample is dropped, oOvf is set to 1 and stays 1 until reset. The sequence in flight is unaffected.
- iEnSample in the same cycle as the DONE->IDLE transition (cycle 13): not accepted, because oReady=0, so it sets oOvf. It is accepted at cycle 14 or later.
- No arithmetic is performed; samples and coefficients pass through unmodified, bit-exact.
- Exactly 10 oEnMul pulses per accepted sample, never fewer or more, so the downstream counter cannot drift.

Decomposition:
- Shared FIR package holds:
  - tap count 10;
  - DATA_W and COEFF_W defaults;
  - state encoding IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3.
- One natural sub-module, fir_delay_line: 10 x DATA_W shift register with a shift-enable input and reset-to-zero. The sequencer FSM, SRAM read port and output stage stay in the top.

Test Plan:
- Reset: assert iRsn mid-RUN (cycle 5). Required: outputs immediately at reset values; after release oReady=1 and no oEnMul pulse appears.
- Single sample: SRAM holds coefficient k = 16'd(100+k); accept iFirIn=3'sd3. Required:
  - oDelay_0=3, other taps 0;
  - oEnMul high cycles 3..12 with oCoeff=100..109 in order;
  - oDone at cycle 13; oReady at cycle 14.
- Shift order: accept samples 1, 2, -1, -4, back to back at each oReady. Required: after the 4th accept oDelay_0..3 = -4, -1, 2, 1 and taps 4..9 = 0. Taps are constant during every oEnMul window.
- Fill and wrap: accept 11 samples of values 1..3,-4..-1 cycling. Required: after the 11th accept oDelay_9 equals the 2nd sample; the 1st sample is discarded.
- Overrun: iEnSample at cycle 6 and at cycle 13 of a sequence. Required: both dropped, oOvf=1 and sticky, taps unchanged, pulse count still exactly 10.
- Negative extremes: coefficients 16'sh8000 and 16'sh7FFF at k=0,1 with sample -4. Required: oCoeff is bit-exact, 8000h then 7FFFh, on pulses 0 and 1.

Source files
------------

// File: rtl/fir_tap_sequencer_pkg.sv
// Shared FIR constants and the tap-sequencer state encoding.
package fir_tap_sequencer_pkg;
  localparam int FIR_TAPS    = 10;
  localparam int FIR_DATA_W  = 3;
  localparam int FIR_COEFF_W = 16;
  localparam int FIR_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sample-in, coefficient SRAM read port and multiplier-side bundle of the tap sequencer.
// master = sequencer side, slave = environment (sample source, SRAM, multiplier).
interface fir_tap_sequencer_if
  import fir_tap_sequencer_pkg::*;
#(
  parameter int DATA_W  = FIR_DATA_W,
  parameter int COEFF_W = FIR_COEFF_W,
  parameter int ADDR_W  = 4
);
  logic                      iEnSample;
  logic signed [DATA_W-1:0]  iFirIn;
  logic                      oReady;
  logic                      oCsnRam;
  logic [ADDR_W-1:0]         oAddrRam;
  logic signed [COEFF_W-1:0] iRdDtRam;
  logic                      oEnMul;
  logic signed [COEFF_W-1:0] oCoeff;
  logic signed [DATA_W-1:0]  oDelay_0, oDelay_1, oDelay_2, oDelay_3, oDelay_4;
  logic signed [DATA_W-1:0]  oDelay_5, oDelay_6, oDelay_7, oDelay_8, oDelay_9;
  logic                      oDone;
  logic                      oOvf;

  modport master (
    input  iEnSample, iFirIn, iRdDtRam,
    output oReady, oCsnRam, oAddrRam, oEnMul, oCoeff, oDone, oOvf,
    output oDelay_0, oDelay_1, oDelay_2, oDelay_3, oDelay_4,
    output oDelay_5, oDelay_6, oDelay_7, oDelay_8, oDelay_9
  );

  modport slave (
    output iEnSample, iFirIn, iRdDtRam,
    input  oReady, oCsnRam, oAddrRam, oEnMul, oCoeff, oDone, oOvf,
    input  oDelay_0, oDelay_1, oDelay_2, oDelay_3, oDelay_4,
    input  oDelay_5, oDelay_6, oDelay_7, oDelay_8, oDelay_9
  );
endinterface

// File: rtl/fir_tap_sequencer_delay.sv
// 10-tap sample delay line; taps[0] is the newest sample, shifts only on shift_en.
// Zero latency to taps after the shifting edge; no backpressure.
module fir_delay_line
  import fir_tap_sequencer_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int TAPS   = FIR_TAPS
) (
  input  logic                         iClk12M,
  input  logic                         iRsn,
  input  logic                         shift_en,
  input  logic [DATA_W-1:0]            din,
  output logic [TAPS-1:0][DATA_W-1:0]  taps
);
  always_ff @(posedge iClk12M or posedge iRsn) begin
    if (iRsn) begin
      taps <= '0;
    end else if (shift_en) begin
      taps <= {taps[TAPS-2:0], din};
    end
  end
endmodule

// File: rtl/fir_tap_sequencer.sv
// Accepts a sample, reads 10 coefficients and issues 10 contiguous multiply-enable pulses.
// oDone 13 cycles after accept, oReady again at 14; samples arriving while busy are dropped and flagged in oOvf.
module fir_tap_sequencer
  import fir_tap_sequencer_pkg::*;
#(
  parameter int DATA_W     = FIR_DATA_W,
  parameter int COEFF_W    = FIR_COEFF_W,
  parameter int ADDR_W     = 4,
  parameter int COEFF_BASE = 0
) (
  input  logic                 iClk12M,
  input  logic                 iRsn,
  fir_tap_sequencer_if.master  bus
);
  state_t                     state_q, state_nxt;
  logic [FIR_CNT_W-1:0]       cnt_q, cnt_nxt;
  logic                       csn_q, csn_nxt;
  logic [ADDR_W-1:0]          addr_q, addr_nxt;
  logic                       shift_en;
  logic                       rd_pend_q;
  logic                       en_mul_q;
  logic [COEFF_W-1:0]         coeff_q;
  logic                       ovf_q;
  logic [FIR_TAPS-1:0][DATA_W-1:0] taps;

  always_ff @(posedge iClk12M or posedge iRsn) begin
    if (iRsn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      csn_q   <= 1'b1;
      addr_q  <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      csn_q   <= csn_nxt;
      addr_q  <= addr_nxt;
    end
  end

  // The read port is registered, so the first read is launched on the accept edge itself.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    csn_nxt   = 1'b1;
    shift_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.iEnSample) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          csn_nxt   = 1'b0;
          shift_en  = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == FIR_CNT_W'(FIR_TAPS - 1)) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
          csn_nxt = 1'b0;
        end
      end
      DRAIN: begin
        if (cnt_q == FIR_CNT_W'(1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    addr_nxt = csn_nxt ? addr_q : ADDR_W'(COEFF_BASE) + ADDR_W'(cnt_nxt);
  end

  // SRAM data lands one cycle after the address; one more register aligns it with oEnMul.
  always_ff @(posedge iClk12M or posedge iRsn) begin
    if (iRsn) begin
      rd_pend_q <= 1'b0;
      en_mul_q  <= 1'b0;
      coeff_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      rd_pend_q <= ~csn_q;
      en_mul_q  <= rd_pend_q;
      if (rd_pend_q) coeff_q <= bus.iRdDtRam;
      if (bus.iEnSample && (state_q != IDLE)) ovf_q <= 1'b1;
    end
  end

  fir_delay_line #(.DATA_W(DATA_W), .TAPS(FIR_TAPS)) u_delay (
    .iClk12M  (iClk12M),
    .iRsn     (iRsn),
    .shift_en (shift_en),
    .din      (bus.iFirIn),
    .taps     (taps)
  );

  assign bus.oReady   = (state_q == IDLE);
  assign bus.oDone    = (state_q == DONE);
  assign bus.oCsnRam  = csn_q;
  assign bus.oAddrRam = addr_q;
  assign bus.oEnMul   = en_mul_q;
  assign bus.oCoeff   = coeff_q;
  assign bus.oOvf     = ovf_q;
  assign bus.oDelay_0 = taps[0];
  assign bus.oDelay_1 = taps[1];
  assign bus.oDelay_2 = taps[2];
  assign bus.oDelay_3 = taps[3];
  assign bus.oDelay_4 = taps[4];
  assign bus.oDelay_5 = taps[5];
  assign bus.oDelay_6 = taps[6];
  assign bus.oDelay_7 = taps[7];
  assign bus.oDelay_8 = taps[8];
  assign bus.oDelay_9 = taps[9];
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with a one-cycle-latency coefficient SRAM model.
module tb_fir_tap_sequencer;
  logic iClk12M = 1'b0;
  logic rst     = 1'b1;
  always #5 iClk12M = ~iClk12M;

  fir_tap_sequencer_if #(.DATA_W(3), .COEFF_W(16), .ADDR_W(4)) bus ();

  fir_tap_sequencer #(.DATA_W(3), .COEFF_W(16), .ADDR_W(4), .COEFF_BASE(0)) dut (
    .iClk12M (iClk12M),
    .iRsn    (rst),
    .bus     (bus)
  );

  logic [15:0] mem [16];
  logic [3:0]  rd_log [$];

  always @(posedge iClk12M) begin
    if (!bus.oCsnRam) begin
      bus.iRdDtRam <= mem[bus.oAddrRam];
      rd_log.push_back(bus.oAddrRam);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] got_coeff [10];
  int n_pulse, first_cyc, last_cyc, done_cyc, n_done, ready_cyc;
  bit contiguous, taps_moved;

  function automatic logic [29:0] taps_vec();
    return {bus.oDelay_9, bus.oDelay_8, bus.oDelay_7, bus.oDelay_6, bus.oDelay_5,
            bus.oDelay_4, bus.oDelay_3, bus.oDelay_2, bus.oDelay_1, bus.oDelay_0};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge iClk12M);
    rst = 1'b0;
    @(negedge iClk12M);
  endtask

  // Accepts sample s, optionally strobes iEnSample at cycles ovf_a/ovf_b, records the sequence until oReady.
  task automatic run_seq(input logic signed [2:0] s, input int ovf_a, input int ovf_b);
    logic [29:0] snap;
    int w;
    w = 0;
    while (!bus.oReady && w < 20) begin
      @(negedge iClk12M);
      w++;
    end
    n_checks++;
    if (!bus.oReady) begin
      n_fail++;
      $display("FAIL accept_wait: oReady=%0b after %0d cycles, required 1", bus.oReady, w);
    end
    bus.iEnSample = 1'b1;
    bus.iFirIn    = s;
    @(negedge iClk12M);
    bus.iEnSample = 1'b0;
    n_pulse = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; n_done = 0; ready_cyc = -1;
    contiguous = 1'b1; taps_moved = 1'b0;
    snap = taps_vec();
    for (int c = 1; c <= 20; c++) begin
      if (bus.oEnMul) begin
        if (n_pulse < 10) got_coeff[n_pulse] = bus.oCoeff;
        if (last_cyc >= 0 && last_cyc != c - 1) contiguous = 1'b0;
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        n_pulse++;
      end
      if (bus.oDone) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (bus.oReady && ready_cyc < 0) ready_cyc = c;
      if (taps_vec() !== snap) taps_moved = 1'b1;
      bus.iEnSample = (c == ovf_a) || (c == ovf_b);
      bus.iFirIn    = 3'sd2;
      if (ready_cyc >= 0) break;
      @(negedge iClk12M);
    end
    bus.iEnSample = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (bus.oReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", bus.oReady); end
    n_checks++; if (bus.oCsnRam !== 1'b1) begin n_fail++; $display("FAIL reset_csn: got %0b want 1", bus.oCsnRam); end
    n_checks++; if (bus.oEnMul !== 1'b0) begin n_fail++; $display("FAIL reset_enmul: got %0b want 0", bus.oEnMul); end
    n_checks++; if (bus.oDone !== 1'b0 || bus.oOvf !== 1'b0) begin n_fail++; $display("FAIL reset_done_ovf: got %0b/%0b want 0/0", bus.oDone, bus.oOvf); end
    n_checks++; if (bus.oCoeff !== 16'h0 || bus.oAddrRam !== 4'h0) begin n_fail++; $display("FAIL reset_coeff_addr: got %0h/%0h want 0/0", bus.oCoeff, bus.oAddrRam); end
    n_checks++; if (taps_vec() !== 30'h0) begin n_fail++; $display("FAIL reset_taps: got %0h want 0", taps_vec()); end
  endtask

  task automatic test_single();
    for (int k = 0; k < 16; k++) mem[k] = 16'(100 + k);
    rd_log.delete();
    run_seq(3'sd3, -1, -1);
    n_checks++; if (taps_vec() !== 30'h3) begin n_fail++; $display("FAIL single_taps: got %0h want 3", taps_vec()); end
    n_checks++; if (n_pulse !== 10 || !contiguous) begin n_fail++; $display("FAIL single_pulses: got %0d contiguous=%0b want 10/1", n_pulse, contiguous); end
    n_checks++; if (first_cyc !== 3 || last_cyc !== 12) begin n_fail++; $display("FAIL single_window: got %0d..%0d want 3..12", first_cyc, last_cyc); end
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (got_coeff[k] !== 16'(100 + k)) begin n_fail++; $display("FAIL single_coeff%0d: got %0d want %0d", k, got_coeff[k], 100 + k); end
    end
    n_checks++; if (done_cyc !== 13 || n_done !== 1) begin n_fail++; $display("FAIL single_done: got cycle %0d count %0d want 13/1", done_cyc, n_done); end
    n_checks++; if (ready_cyc !== 14) begin n_fail++; $display("FAIL single_ready: got %0d want 14", ready_cyc); end
    n_checks++; if (rd_log.size() !== 10) begin n_fail++; $display("FAIL single_reads: got %0d want 10", rd_log.size()); end
    for (int k = 0; k < 10 && k < rd_log.size(); k++) begin
      n_checks++;
      if (rd_log[k] !== 4'(k)) begin n_fail++; $display("FAIL single_addr%0d: got %0d want %0d", k, rd_log[k], k); end
    end
    n_checks++; if (bus.oOvf !== 1'b0 || taps_moved) begin n_fail++; $display("FAIL single_ovf_taps: ovf=%0b moved=%0b want 0/0", bus.oOvf, taps_moved); end
  endtask

  task automatic test_shift_order();
    logic signed [2:0] s [4];
    s[0] = 3'sd1; s[1] = 3'sd2; s[2] = -3'sd1; s[3] = -3'sd4;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_seq(s[i], -1, -1);
      n_checks++;
      if (n_pulse !== 10 || taps_moved) begin n_fail++; $display("FAIL shift_run%0d: pulses=%0d moved=%0b want 10/0", i, n_pulse, taps_moved); end
    end
    n_checks++; if (bus.oDelay_0 !== -3'sd4) begin n_fail++; $display("FAIL shift_tap0: got %0d want -4", bus.oDelay_0); end
    n_checks++; if (bus.oDelay_1 !== -3'sd1) begin n_fail++; $display("FAIL shift_tap1: got %0d want -1", bus.oDelay_1); end
    n_checks++; if (bus.oDelay_2 !== 3'sd2) begin n_fail++; $display("FAIL shift_tap2: got %0d want 2", bus.oDelay_2); end
    n_checks++; if (bus.oDelay_3 !== 3'sd1) begin n_fail++; $display("FAIL shift_tap3: got %0d want 1", bus.oDelay_3); end
    n_checks++; if (taps_vec() !== {18'h0, 3'b001, 3'b010, 3'b111, 3'b100}) begin n_fail++; $display("FAIL shift_upper: got %0h want %0h", taps_vec(), {18'h0, 3'b001, 3'b010, 3'b111, 3'b100}); end
  endtask

  task automatic test_fill_wrap();
    int total;
    int m;
    total = 0;
    for (int i = 0; i < 11; i++) begin
      m = i % 7;
      run_seq(3'((m < 3) ? m + 1 : m - 7), -1, -1);
      total += n_pulse;
    end
    n_checks++; if (total !== 110) begin n_fail++; $display("FAIL fill_pulses: got %0d want 110", total); end
    n_checks++; if (bus.oDelay_9 !== 3'sd2) begin n_fail++; $display("FAIL fill_tap9: got %0d want 2", bus.oDelay_9); end
    n_checks++;
    if (taps_vec() !== {3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b001, 3'b010, 3'b011, 3'b100}) begin
      n_fail++; $display("FAIL fill_taps: got %0h want %0h", taps_vec(),
        {3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b001, 3'b010, 3'b011, 3'b100});
    end
  endtask

  task automatic test_overrun();
    n_checks++; if (bus.oOvf !== 1'b0) begin n_fail++; $display("FAIL ovr_pre: got %0b want 0", bus.oOvf); end
    run_seq(-3'sd3, 6, 13);
    n_checks++; if (bus.oOvf !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %0b want 1", bus.oOvf); end
    n_checks++; if (n_pulse !== 10 || !contiguous) begin n_fail++; $display("FAIL ovr_pulses: got %0d contiguous=%0b want 10/1", n_pulse, contiguous); end
    n_checks++; if (taps_moved) begin n_fail++; $display("FAIL ovr_taps: moved=%0b want 0", taps_moved); end
    n_checks++; if (done_cyc !== 13 || ready_cyc !== 14) begin n_fail++; $display("FAIL ovr_timing: done=%0d ready=%0d want 13/14", done_cyc, ready_cyc); end
    n_checks++; if (bus.oDelay_0 !== -3'sd3) begin n_fail++; $display("FAIL ovr_tap0: got %0d want -3", bus.oDelay_0); end
    run_seq(3'sd1, -1, -1);
    n_checks++; if (bus.oOvf !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %0b want 1", bus.oOvf); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    bus.iEnSample = 1'b1;
    bus.iFirIn    = 3'sd3;
    @(negedge iClk12M);
    bus.iEnSample = 1'b0;
    repeat (4) @(negedge iClk12M);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.oEnMul !== 1'b0 || bus.oCsnRam !== 1'b1) begin n_fail++; $display("FAIL rmid_enmul_csn: got %0b/%0b want 0/1", bus.oEnMul, bus.oCsnRam); end
    n_checks++; if (bus.oOvf !== 1'b0 || bus.oDone !== 1'b0) begin n_fail++; $display("FAIL rmid_ovf_done: got %0b/%0b want 0/0", bus.oOvf, bus.oDone); end
    n_checks++; if (bus.oCoeff !== 16'h0 || bus.oAddrRam !== 4'h0) begin n_fail++; $display("FAIL rmid_coeff_addr: got %0h/%0h want 0/0", bus.oCoeff, bus.oAddrRam); end
    n_checks++; if (taps_vec() !== 30'h0 || bus.oReady !== 1'b1) begin n_fail++; $display("FAIL rmid_taps_ready: got %0h/%0b want 0/1", taps_vec(), bus.oReady); end
    @(negedge iClk12M);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge iClk12M);
      if (bus.oEnMul) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rmid_pulses: got %0d want 0", pulses); end
    n_checks++; if (bus.oReady !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %0b want 1", bus.oReady); end
  endtask

  task automatic test_extremes();
    mem[0] = 16'h8000;
    mem[1] = 16'h7FFF;
    run_seq(-3'sd4, -1, -1);
    n_checks++; if (got_coeff[0] !== 16'h8000) begin n_fail++; $display("FAIL ext_coeff0: got %0h want 8000", got_coeff[0]); end
    n_checks++; if (got_coeff[1] !== 16'h7FFF) begin n_fail++; $display("FAIL ext_coeff1: got %0h want 7fff", got_coeff[1]); end
    n_checks++; if (got_coeff[2] !== 16'd102) begin n_fail++; $display("FAIL ext_coeff2: got %0h want 66", got_coeff[2]); end
    n_checks++; if (bus.oDelay_0 !== -3'sd4 || n_pulse !== 10) begin n_fail++; $display("FAIL ext_tap_pulses: got %0d/%0d want -4/10", bus.oDelay_0, n_pulse); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iEnSample = 1'b0;
    bus.iFirIn    = '0;
    bus.iRdDtRam  = '0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    rst = 1'b1;
    repeat (2) @(negedge iClk12M);
    test_reset();
    rst = 1'b0;
    @(negedge iClk12M);
    test_single();
    test_shift_order();
    test_fill_wrap();
    test_overrun();
    test_reset_mid();
    test_extremes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
